riscv_mc_controller: RTL and testbench

RISCV_MC_CONTROLLER -- requirements
Module: riscv_mc_controller

---
 rtl/riscv_mc_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_riscv_mc_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_controller.sv
// ============================================================================
// Module   : riscv_mc_controller
// Brief    : Multi-cycle RISC-V main controller (FSM + ALU/immediate decode).
//            Optional MC_ILLEGAL_HALT_EN parks the FSM in HALT on a bad opcode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_mc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_JALR     = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
`ifdef MC_ILLEGAL_HALT_EN
    localparam logic [3:0] S_HALT     = 4'd13;
`endif

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_XOR = 3'b100;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_dec_state;
    logic [2:0] w_alu_op;
    logic [2:0] w_imm_dec;
    logic       w_op_legal;

    // Register-register subtract is the only funct7-sensitive encoding.
    always_comb begin
        w_alu_op = C_ALU_ADD;
        case (funct3)
            3'b000:  w_alu_op = ((r_state == S_EXECR) && funct7) ? C_ALU_SUB : C_ALU_ADD;
            3'b010:  w_alu_op = C_ALU_SLT;
            3'b100:  w_alu_op = C_ALU_XOR;
            3'b110:  w_alu_op = C_ALU_OR;
            3'b111:  w_alu_op = C_ALU_AND;
            default: w_alu_op = C_ALU_ADD;
        endcase
    end

    always_comb begin
        w_imm_dec  = 3'b000;
        w_op_legal = 1'b1;
        case (op)
            C_OP_LOAD, C_OP_ITYPE, C_OP_JALR, C_OP_RTYPE: w_imm_dec = 3'b000;
            C_OP_STORE:  w_imm_dec = 3'b001;
            C_OP_BRANCH: w_imm_dec = 3'b010;
            C_OP_JAL:    w_imm_dec = 3'b011;
            C_OP_LUI:    w_imm_dec = 3'b100;
            default:     w_op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    C_OP_LOAD, C_OP_STORE: w_next = S_MEMADR;
                    C_OP_RTYPE:  w_next = S_EXECR;
                    C_OP_ITYPE:  w_next = S_EXECI;
                    C_OP_JAL:    w_next = S_JAL;
                    C_OP_JALR:   w_next = S_JALR;
                    C_OP_BRANCH: w_next = S_BRANCH;
                    C_OP_LUI:    w_next = S_LUI;
`ifdef MC_ILLEGAL_HALT_EN
                    default:     w_next = S_HALT;
`else
                    default:     w_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   w_next = (op == C_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            S_JALR:     w_next = S_ALUWB;
`ifdef MC_ILLEGAL_HALT_EN
            S_HALT:     w_next = S_HALT;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // During reset the datapath sees the FETCH selects with every write enable gated off.
    assign w_dec_state = rst ? S_FETCH : r_state;

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = C_ALU_ADD;
        ImmSrc     = 3'b000;
        illegal    = 1'b0;
        case (w_dec_state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = w_imm_dec;
                illegal = ~w_op_legal;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = w_alu_op;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_op;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = C_ALU_SUB;
                case (funct3)
                    3'b000:  PCWrite = zero;
                    3'b001:  PCWrite = ~zero;
                    default: PCWrite = 1'b0;
                endcase
            end
            S_LUI: begin
                ImmSrc    = 3'b100;
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
            end
`ifdef MC_ILLEGAL_HALT_EN
            S_HALT:     illegal = 1'b1;
`endif
            default: ;
        endcase
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_riscv_mc_controller.sv
// ============================================================================
// Module   : tb_riscv_mc_controller
// Brief    : Directed self-checking bench for riscv_mc_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_mc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7 = 1'b0;
    logic       zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    int n_checks = 0;
    int n_errors = 0;

    riscv_mc_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Packed view: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,illegal}
    logic [17:0] w_obs;
    assign w_obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};

    function automatic logic [17:0] pk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic [2:0] imm,
                                       input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill};
    endfunction

    task automatic check(input string tag, input logic [17:0] exp);
        #1;
        n_checks++;
        assert (w_obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, w_obs, exp);
        end
        n_checks++;
        assert ((32'(MemWrite) + 32'(RegWrite) + 32'(IRWrite)) <= 32'd1) else begin
            n_errors++;
            $error("FAIL %s_onehot: observed mw=%b rw=%b irw=%b expected at most one", tag,
                   MemWrite, RegWrite, IRWrite);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [17:0] e_fetch, e_rst, e_dec_i;

    initial begin
        e_fetch = pk(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
        e_rst   = pk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);
        e_dec_i = pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 0);

        step(); step();
        check("reset", e_rst);

        // lw
        rst = 1'b0; op = 7'b0000011;
        check("lw_fetch", e_fetch);
        step(); check("lw_decode", e_dec_i);
        step(); check("lw_memadr", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        step(); check("lw_memread", pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        step(); check("lw_memwb", pk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        step(); check("lw_refetch", e_fetch);

        // sw
        op = 7'b0100011;
        step(); check("sw_decode", pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b001, 0));
        step(); check("sw_memadr", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        step(); check("sw_memwrite", pk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        step(); check("sw_refetch", e_fetch);

        // R-type, ALU decode swept within the EXECR cycle
        op = 7'b0110011; funct3 = 3'b000; funct7 = 1'b1;
        step(); check("r_decode", e_dec_i);
        step(); check("r_sub", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0));
        funct7 = 1'b0;
        check("r_add", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0));
        funct3 = 3'b010;
        check("r_slt", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b101, 3'b000, 0));
        funct3 = 3'b100;
        check("r_xor", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b100, 3'b000, 0));
        funct3 = 3'b110;
        check("r_or", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 3'b000, 0));
        funct3 = 3'b001; funct7 = 1'b1;
        check("r_f3_001", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0));
        step(); check("r_aluwb", pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        step(); check("r_refetch", e_fetch);

        // I-type: funct7 must not produce sub
        op = 7'b0010011; funct3 = 3'b000; funct7 = 1'b1;
        step(); check("i_decode", e_dec_i);
        step(); check("i_add_f7", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        funct3 = 3'b111;
        check("i_and", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000, 0));
        step(); check("i_aluwb", pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        step(); check("i_refetch", e_fetch);

        // Branch: PCWrite follows zero / ~zero / 0
        op = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        step(); check("b_decode", pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 0));
        step(); check("beq_taken", pk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0));
        zero = 1'b0;
        check("beq_not", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0));
        funct3 = 3'b001;
        check("bne_taken", pk(1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0));
        zero = 1'b1;
        check("bne_not", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0));
        funct3 = 3'b100; zero = 1'b0;
        check("b_other", pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 0));
        step(); check("b_refetch", e_fetch);

        // jal
        op = 7'b1101111; funct3 = 3'b000;
        step(); check("jal_decode", pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b011, 0));
        step(); check("jal_exec", pk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0));
        step(); check("jal_aluwb", pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        step(); check("jal_refetch", e_fetch);

        // jalr
        op = 7'b1100111;
        step(); check("jalr_decode", e_dec_i);
        step(); check("jalr_exec", pk(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 3'b000, 3'b000, 0));
        step(); check("jalr_aluwb", pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        step(); check("jalr_refetch", e_fetch);

        // lui
        op = 7'b0110111;
        step(); check("lui_decode", pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b100, 0));
        step(); check("lui_exec", pk(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 0));
        step(); check("lui_refetch", e_fetch);

        // Unsupported opcode
        op = 7'b1111111;
        step(); check("ill_decode", pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 1));
`ifdef MC_ILLEGAL_HALT_EN
        for (int i = 0; i < 10; i++) begin
            step(); check("ill_halt", pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1));
        end
        rst = 1'b1;
        check("halt_rst", e_rst);
        step();
        rst = 1'b0;
        check("halt_refetch", e_fetch);
`else
        step(); check("ill_refetch", e_fetch);
`endif

        // Reset asserted mid-load in MEMREAD
        op = 7'b0000011;
        step(); check("rlw_decode", e_dec_i);
        step(); step(); check("rlw_memread", pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0));
        rst = 1'b1;
        check("rlw_rst", e_rst);
        step(); check("rlw_rst_held", e_rst);
        rst = 1'b0;
        check("rlw_refetch", e_fetch);
        step(); check("rlw_decode2", e_dec_i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
